// File: rtl/i2c_slave_regfile.sv
// I2C target with a byte-wide register file, oversampling SCL/SDA on clk.
// Optional macro I2C_GLITCH_FILTER_EN adds a 3-sample stability filter on both inputs.
`timescale 1ns/1ps
module i2c_slave_regfile #(
  parameter int NUM_REGS = 16
) (
  input  logic       clk,
  input  logic       scl,
  inout  wire        sda,
  input  logic [6:0] slave_addr,
  input  logic       rst
);

  localparam int PW = $clog2(NUM_REGS);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  state_t        state, state_nx;
  logic [3:0]    bit_cnt;
  logic [7:0]    shift_q;
  logic [7:0]    tx_q;
  logic [PW-1:0] ptr;
  logic [7:0]    regs [NUM_REGS];
  logic          sda_oe;

  logic [1:0] scl_sync, sda_sync;
  logic       scl_cur, sda_cur, scl_prev, sda_prev;

  // Open-drain: only ever pull low or release.
  assign sda = sda_oe ? 1'b0 : 1'bz;

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda};
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  logic [1:0] scl_hist, sda_hist;
  logic       scl_hold, sda_hold;

  // Output follows the input only once three consecutive samples agree.
  always_comb begin
    scl_cur = (scl_hist == {2{scl_sync[1]}}) ? scl_sync[1] : scl_hold;
    sda_cur = (sda_hist == {2{sda_sync[1]}}) ? sda_sync[1] : sda_hold;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_hist <= 2'b11;
      sda_hist <= 2'b11;
      scl_hold <= 1'b1;
      sda_hold <= 1'b1;
    end else begin
      scl_hist <= {scl_hist[0], scl_sync[1]};
      sda_hist <= {sda_hist[0], sda_sync[1]};
      scl_hold <= scl_cur;
      sda_hold <= sda_cur;
    end
  end
`else
  always_comb begin
    scl_cur = scl_sync[1];
    sda_cur = sda_sync[1];
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_prev <= scl_cur;
      sda_prev <= sda_cur;
    end
  end

  logic       scl_rise, scl_fall, start_det, stop_det, addr_match;
  logic [7:0] rx_byte;

  assign scl_rise   = scl_cur & ~scl_prev;
  assign scl_fall   = ~scl_cur & scl_prev;
  assign start_det  = scl_cur & scl_prev & sda_prev & ~sda_cur;
  assign stop_det   = scl_cur & scl_prev & ~sda_prev & sda_cur;
  assign rx_byte    = {shift_q[6:0], sda_cur};
  assign addr_match = (shift_q[7:1] == slave_addr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // NOTE: state_nx gets a default before the case so no latch is inferred.
  always_comb begin
    state_nx = state;
    if (start_det) begin
      state_nx = ADDR;
    end else if (stop_det) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:      state_nx = IDLE;
        ADDR:      if (scl_fall && bit_cnt == 4'd8) state_nx = addr_match ? ADDR_ACK : IDLE;
        ADDR_ACK:  if (scl_fall) state_nx = shift_q[0] ? RDATA : REG;
        REG:       if (scl_fall && bit_cnt == 4'd8) state_nx = REG_ACK;
        REG_ACK:   if (scl_fall) state_nx = WDATA;
        WDATA:     if (scl_fall && bit_cnt == 4'd8) state_nx = WDATA_ACK;
        WDATA_ACK: if (scl_fall) state_nx = WDATA;
        RDATA:     if (scl_fall && bit_cnt == 4'd8) state_nx = RDATA_ACK;
        RDATA_ACK: begin
          if (scl_rise && sda_cur) state_nx = IDLE;
          else if (scl_fall)       state_nx = RDATA;
        end
        default:   state_nx = IDLE;
      endcase
    end
  end

  // NOTE: the register file is reset explicitly because all registers must read 0x00 after rst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt <= '0;
      shift_q <= '0;
      tx_q    <= '0;
      ptr     <= '0;
      sda_oe  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (start_det || stop_det) begin
      bit_cnt <= '0;
      sda_oe  <= 1'b0;
    end else begin
      unique case (state)
        ADDR, REG, WDATA: begin
          if (scl_rise && bit_cnt < 4'd8) begin
            shift_q <= rx_byte;
            bit_cnt <= bit_cnt + 4'd1;
            // A byte only takes effect once its 8th bit has been sampled.
            if (bit_cnt == 4'd7 && state == REG) ptr <= rx_byte[PW-1:0];
            if (bit_cnt == 4'd7 && state == WDATA) begin
              regs[ptr] <= rx_byte;
              ptr       <= ptr + 1'b1;
            end
          end
          if (scl_fall && bit_cnt == 4'd8) begin
            bit_cnt <= '0;
            sda_oe  <= (state != ADDR) || addr_match;
          end
        end
        ADDR_ACK, REG_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            sda_oe <= 1'b0;
            if (state == ADDR_ACK && shift_q[0]) begin
              sda_oe <= ~regs[ptr][7];
              tx_q   <= {regs[ptr][6:0], 1'b0};
            end
          end
        end
        RDATA: begin
          if (scl_rise && bit_cnt < 4'd8) bit_cnt <= bit_cnt + 4'd1;
          if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe  <= 1'b0;
              bit_cnt <= '0;
              ptr     <= ptr + 1'b1;
            end else begin
              sda_oe <= ~tx_q[7];
              tx_q   <= {tx_q[6:0], 1'b0};
            end
          end
        end
        RDATA_ACK: begin
          if (scl_fall) begin
            sda_oe <= ~regs[ptr][7];
            tx_q   <= {regs[ptr][6:0], 1'b0};
          end
        end
        default: sda_oe <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Scoreboard bench: two targets (0x12, 0x0F) on one open-drain bus driven by a bit-banged master.
`timescale 1ns/1ps
module tb_i2c_slave_regfile;

  localparam int Q = 5;  // clk cycles per quarter SCL period

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic scl = 1'b1;
  logic m_sda = 1'b1;
  wire  sda_bus;

  always #5 clk = ~clk;

  pullup (sda_bus);
  assign sda_bus = m_sda ? 1'bz : 1'b0;

  i2c_slave_regfile #(.NUM_REGS(16)) u_a (
    .clk(clk), .scl(scl), .sda(sda_bus), .slave_addr(7'h12), .rst(rst)
  );
  i2c_slave_regfile #(.NUM_REGS(16)) u_b (
    .clk(clk), .scl(scl), .sda(sda_bus), .slave_addr(7'h0F), .rst(rst)
  );

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] act_q[$];
  int          checks = 0;
  int          errors = 0;
  int          b_low_cnt = 0;

  always @(posedge clk) if (u_b.sda_oe) b_low_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic push_exp(input string name, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic observe(input string name, input logic [31:0] exp_v, input logic [31:0] act);
    push_exp(name, exp_v);
    act_q.push_back(act);
  endtask

  // Monitor: pairs each observed DUT response with the oldest expectation.
  initial begin : monitor
    exp_t        e;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      while (act_q.size() > 0) begin
        a = act_q.pop_front();
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_observation: got 0x%0h with no expectation queued", a);
        end else begin
          e = exp_q.pop_front();
          check(e.name, a, e.val);
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, output logic s);
    m_sda = b;   wait_clk(Q);
    scl   = 1'b1; wait_clk(Q);
    s     = sda_bus; wait_clk(Q);
    scl   = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wait_clk(Q);
    scl   = 1'b1; wait_clk(Q);
    m_sda = 1'b0; wait_clk(Q);
    scl   = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wait_clk(Q);
    scl   = 1'b1; wait_clk(Q);
    m_sda = 1'b1; wait_clk(2 * Q);
  endtask

  task automatic write_byte(input string name, input logic [7:0] d, input logic ack_exp);
    logic s;
    push_exp(name, {31'd0, ack_exp});
    for (int i = 7; i >= 0; i--) send_bit(d[i], s);
    send_bit(1'b1, s);
    act_q.push_back({31'd0, s});
  endtask

  task automatic read_byte(input string name, input logic [7:0] exp_v, input logic m_ack);
    logic [7:0] d;
    logic       s;
    push_exp(name, {24'd0, exp_v});
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, s);
      d[i] = s;
    end
    send_bit(m_ack, s);
    act_q.push_back({24'd0, d});
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation did not finish within 2 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic s;
    logic [7:0] wdat [8];
    wdat = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};

    wait_clk(5);
    rst = 1'b1;
    wait_clk(5);
    observe("reset_sda_released", 32'd1, {31'd0, sda_bus});
    observe("reset_state_a", 32'd0, 32'(u_a.state));
    observe("reset_state_b", 32'd0, 32'(u_b.state));

    // Write 0x00..0x77 into regs 0..7 of target 0x12.
    i2c_start();
    write_byte("w1_addr_ack", 8'h24, 1'b0);
    write_byte("w1_reg_ack", 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) write_byte($sformatf("w1_data%0d_ack", i), wdat[i], 1'b0);
    i2c_stop();
    observe("w1_other_target_silent", 32'd0, 32'(b_low_cnt));

    // Read all eight back from pointer 0.
    i2c_start();
    write_byte("r0_addr_w_ack", 8'h24, 1'b0);
    write_byte("r0_reg_ack", 8'h00, 1'b0);
    i2c_start();
    write_byte("r0_addr_r_ack", 8'h25, 1'b0);
    for (int i = 0; i < 8; i++) read_byte($sformatf("r0_byte%0d", i), wdat[i], (i == 7));
    i2c_stop();

    // Unknown address 0x11: every ACK slot stays high.
    i2c_start();
    write_byte("a11_addr_nack", 8'h22, 1'b1);
    write_byte("a11_reg_nack", 8'h03, 1'b1);
    i2c_start();
    write_byte("a11_addr_r_nack", 8'h23, 1'b1);
    i2c_stop();

    // Pointer write, repeated START read: 0x33, 0x44, 0x55 then NACK.
    i2c_start();
    write_byte("r3_addr_w_ack", 8'h24, 1'b0);
    write_byte("r3_reg_ack", 8'h03, 1'b0);
    i2c_start();
    write_byte("r3_addr_r_ack", 8'h25, 1'b0);
    read_byte("r3_byte0", 8'h33, 1'b0);
    read_byte("r3_byte1", 8'h44, 1'b0);
    read_byte("r3_byte2", 8'h55, 1'b1);
    observe("r3_sda_released_after_nack", 32'd1, {31'd0, sda_bus});
    observe("r3_state_idle_after_nack", 32'd0, 32'(u_a.state));
    i2c_stop();

    // Pointer wrap at NUM_REGS.
    i2c_start();
    write_byte("wrap_addr_ack", 8'h24, 1'b0);
    write_byte("wrap_reg_ack", 8'h0F, 1'b0);
    write_byte("wrap_d0_ack", 8'hA5, 1'b0);
    write_byte("wrap_d1_ack", 8'h5A, 1'b0);
    i2c_stop();
    i2c_start();
    write_byte("wrap_rd_addr_w_ack", 8'h24, 1'b0);
    write_byte("wrap_rd_reg_ack", 8'h0F, 1'b0);
    i2c_start();
    write_byte("wrap_rd_addr_r_ack", 8'h25, 1'b0);
    read_byte("wrap_reg15", 8'hA5, 1'b0);
    read_byte("wrap_reg0", 8'h5A, 1'b0);
    read_byte("wrap_reg1", 8'h11, 1'b1);
    i2c_stop();

    // Reset during the 4th bit of a read byte (0xA5: the target pulls that bit low).
    i2c_start();
    write_byte("rst_addr_w_ack", 8'h24, 1'b0);
    write_byte("rst_reg_ack", 8'h0F, 1'b0);
    i2c_start();
    write_byte("rst_addr_r_ack", 8'h25, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, s);
    m_sda = 1'b1; wait_clk(Q);
    scl   = 1'b1; wait_clk(Q);
    observe("rst_bit4_driven_low", 32'd0, {31'd0, sda_bus});
    rst = 1'b0;
    #1;
    observe("rst_sda_released", 32'd1, {31'd0, sda_bus});
    observe("rst_state_idle", 32'd0, 32'(u_a.state));
    wait_clk(4 * Q);
    rst = 1'b1;
    wait_clk(4 * Q);

    // Next transaction reads all 16 registers from pointer 0: all cleared.
    i2c_start();
    write_byte("post_rst_addr_r_ack", 8'h25, 1'b0);
    for (int i = 0; i < 16; i++) read_byte($sformatf("post_rst_reg%0d", i), 8'h00, (i == 15));
    i2c_stop();

    // STOP after 4 bits of a data byte leaves the register unchanged.
    i2c_start();
    write_byte("ps_addr_ack", 8'h24, 1'b0);
    write_byte("ps_reg_ack", 8'h06, 1'b0);
    write_byte("ps_data_ack", 8'h3C, 1'b0);
    i2c_stop();
    i2c_start();
    write_byte("ps2_addr_ack", 8'h24, 1'b0);
    write_byte("ps2_reg_ack", 8'h06, 1'b0);
    for (int i = 7; i >= 4; i--) send_bit(1'b1, s);
    i2c_stop();
    observe("ps2_state_idle", 32'd0, 32'(u_a.state));
    i2c_start();
    write_byte("ps3_addr_w_ack", 8'h24, 1'b0);
    write_byte("ps3_reg_ack", 8'h06, 1'b0);
    i2c_start();
    write_byte("ps3_addr_r_ack", 8'h25, 1'b0);
    read_byte("ps3_reg6_unchanged", 8'h3C, 1'b1);
    i2c_stop();

    observe("other_target_never_drove", 32'd0, 32'(b_low_cnt));

    for (int i = 0; i < 100 && act_q.size() > 0; i++) wait_clk(1);
    wait_clk(2);
    check("pending_observations", 32'(act_q.size()), 32'd0);
    check("pending_expectations", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_slave_regfile.md
Name: i2c_slave_regfile

Overview:
- I2C target (slave) with an internal byte-wide register file, oversampling SCL/SDA on a fast system clock.
- Answers a 7-bit address supplied on a port, so several instances can share one bus.
- Master writes a register pointer, then data bytes with auto-increment.
- Master reads from the current pointer, with auto-increment, after a repeated START.

Parameters:
- NUM_REGS, 16, number of 8-bit registers; power of two; pointer wraps modulo NUM_REGS.

Ports:
- clk  input  1  system clock; frequency ≥ 5x SCL frequency.
- scl  input  1  I2C clock from master; never driven by this block.
- sda  inout  1  I2C data, open-drain: drives 0 or Z only, never 1.
- slave_addr  input  7  device address; static during operation.
- rst  input  1  asynchronous, active-low reset (port order: clk, scl, sda, slave_addr, rst).

Behaviour:
- Input conditioning:
  - scl and sda each pass through a 2-FF synchronizer, then a previous-sample register.
  - Edges are detected on the registered samples. Both signals share identical latency.
- Bus conditions (SCL high):
  - START = sda 1→0. Also recognised as a repeated START in any state.
  - STOP = sda 0→1. Recognised in any state.
- Data timing: SDA is sampled on the SCL rising edge. The block changes its SDA drive only after an SCL falling edge.
- Reset (rst=0), including mid-transfer:
  - sda released (Z); state IDLE; bit counter 0; pointer 0; all registers 0x00.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits, MSB first (7 address bits + R/W).
    - Address ≠ slave_addr → IDLE, sda untouched.
    - Match → ADDR_ACK.
  - ADDR_ACK: drive sda=0 from the falling edge after bit 8 to the falling edge after the 9th clock.
    - R/W=0 → REG.
    - R/W=1 → RDATA; first read byte loaded from regs[pointer].
  - REG: shift 8 bits into the pointer (value modulo NUM_REGS); ACK in REG_ACK → WDATA.
  - WDATA: shift 8 bits, then:
    - write regs[pointer] on completion of the 8th bit;
    - pointer++ (wraps);
    - ACK in WDATA_ACK → WDATA.
  - RDATA: drive each bit MSB first as sda=0 for a 0 and Z for a 1. Set on the falling edge before each bit; the first bit is set on the ACK-ending falling edge. After 8 bits, release sda; pointer++ (wraps).
  - RDATA_ACK: sample master bit on the 9th rising edge.
    - 0 (ACK) → load regs[pointer] → RDATA.
    - 1 (NACK) → IDLE with sda released; waits for STOP/START.
- START in any state:
  - → ADDR, bit counter cleared, sda released.
  - Pointer is kept, so write-pointer then repeated-START read works.
- STOP in any state → IDLE, sda released.
- Simultaneous START/STOP detection with bit activity: the START/STOP condition wins.
- Writes are never partially committed: a STOP or START mid-byte discards the byte.
- No clock stretching; scl is input only.

Optional Feature:
- Macro I2C_GLITCH_FILTER_EN.
  - Defined: after synchronization, scl and sda each pass a 3-sample majority/stability filter. The filtered value changes only after 3 consecutive equal samples. Adds 2 clk of latency to both signals equally; clk must be ≥ 8x SCL.
  - Undefined: no filter; synchronizer output is used directly.

Test Plan:
- Two instances, slave_addr=0x12 and 0x0F.
  - Stimulus: START, 0x24 (0x12,W); reg 0x00; data 0x00,0x11,0x22,0x33,0x44,0x55,0x66,0x77; STOP.
  - Required: instance 0x12 ACKs all 10 bytes, regs[0..7]=0x00..0x77. Instance 0x0F never pulls sda low.
- Address 0x11 write, reg 0x03, repeated START 0x11 read.
  - Required: no instance ACKs; sda stays high for every ACK slot; register contents unchanged.
- After the write test: START 0x12 W, reg 0x03, repeated START 0x12 R, master ACK, ACK, NACK, STOP.
  - Required: read bytes 0x33, 0x44, 0x55. sda is released after the NACK; state IDLE.
- Pointer wrap: write reg 0x0F (NUM_REGS=16), data 0xA5, 0x5A.
  - Required: regs[15]=0xA5, regs[0]=0x5A.
- Assert rst low during the 4th bit of a data byte.
  - Required: sda released within 1 clk; regs all 0x00. The next transaction from START behaves normally.
- STOP after 4 bits of a write byte.
  - Required: target register unchanged; state IDLE.
